tx_digital_front_end: RTL and testbench
=======================================

# tx_digital_front_end

Transmit-side digital front end. It accepts packed baseband I/Q samples from the modulator over a valid/ready stream and buffers them in a small FIFO. Samples are interpolated by 1, 2 or 4 with linear interpolation, then digital gain, DC-offset (LO-leakage) pre-compensation and saturation are applied. The result drives the DAC at the rate set by the DAC's sample strobe. It is the counterpart of the receive DFE on the ADC side.

## Interface
- FIFO_DEPTH, 4, input FIFO entries (power of 2, ≥2)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_data  in  32  sample {I[31:16], Q[15:0]}, two's complement
- s_valid  in  1  s_data valid
- s_ready  out  1  FIFO can accept; equals !full && !rst
- interp_sel  in  2  00→L=1, 01→L=2, 10→L=4, 11→L=1
- gain  in  8  unsigned Q1.7; 0x80 = 1.0
- dc_offset_i, dc_offset_q  in  16 each  signed offset added after gain
- dac_strobe  in  1  DAC requests one output sample (may be high every cycle)
- dac_i, dac_q  out  16 each  signed DAC samples
- dac_valid  out  1  one-cycle pulse per strobe
- clip  out  1  aligned with dac_valid; I or Q saturated on this sample
- underflow  out  1  sticky; strobe found no sample available
- underflow_clr  in  1  clears underflow (set wins if same cycle)

## Operation
- FIFO: push on s_valid && s_ready. When full, s_ready=0 even if a pop occurs the same cycle (no pass-through). No bypass: a sample pushed at edge t is poppable from edge t+1.
- Interpolator state: previous P, current C (per I and Q, reset 0), phase k ∈ 1..L, and a flag need_pop (reset 1).
- Strobe with need_pop=1 and FIFO non-empty:
  - pop; P←C, C←head.
  - latch L from interp_sel. interp_sel is sampled only here.
  - k←1; emit y for k=1.
- Strobe with need_pop=1 and FIFO empty:
  - no pop; state unchanged; underflow←1.
  - dac_i/dac_q hold previous values; dac_valid still pulses; clip=0.
- Strobe with need_pop=0: k←k+1; emit y.
- After emitting k=L, need_pop←1.
- y = P + ((k·(C−P)) >>> log2 L), computed per channel:
  - C−P is 17-bit signed; the product is 19-bit; the shift is arithmetic (floor).
  - y lies within [min(P,C), max(P,C)] and fits 16 bits.
  - k=L yields exactly C.
- Gain stage: g = (y·gain) >>> 7 (signed × unsigned, 25-bit, floor). Then s = g + sign-extended dc_offset.
- Saturate s to [−32768, 32767]. clip=1 if either channel saturated.
- gain and dc_offset are used live, in the cycle the gain stage evaluates.

## Timing
- Pipeline:
  - stage 1 registers y on the strobe edge.
  - stage 2 registers dac_i, dac_q, dac_valid and clip one edge later.
  - Strobe at edge t gives dac_valid high for the cycle after edge t+1: latency 2, throughput 1 sample per cycle.
- Reset state:
  - dac_i = dac_q = 0; dac_valid = clip = underflow = 0.
  - FIFO empty; P = C = 0; need_pop = 1.
  - s_ready = 0 while rst is high and 1 after.
- Reset mid-operation clears all state at once. In-flight pipeline samples are discarded and FIFO contents are lost.
- Simultaneous push and pop with FIFO not full: both occur and occupancy is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH with an extra occupancy bit distinguishing full from empty.

## Test plan
- L=1, gain 0x80, offset 0: push 0x1000_F000, strobe 2 cycles later → dac_i=0x1000, dac_q=0xF000, dac_valid high 2 cycles after strobe, clip=0.
- L=2 from reset: push I=100, then I=300 (Q=0); 4 back-to-back strobes → dac_i = 50, 100, 200, 300 on consecutive cycles.
- L=4: push I=400, Q=−400; 4 strobes → I = 100, 200, 300, 400 and Q = −100, −200, −300, −400. Changing interp_sel mid-segment has no effect until the next pop.
- Saturation:
  - gain 0xFF, I=0x7000 → dac_i=0x7FFF, clip=1.
  - gain 0x80, I=0x8000, dc_offset_i=−1 → dac_i=0x8000, clip=1.
- Underflow: strobe after reset with FIFO empty → dac_valid=1, dac_i=0, underflow=1, stays set. Pulse underflow_clr → 0. Clear and a new underflow in the same cycle → remains 1.
- Backpressure/reset:
  - with no strobes, push 5 samples → s_ready=0 after the 4th.
  - one strobe at L=1 → s_ready=1 the next cycle, and the 5th sample is accepted.
  - assert rst mid-stream → outputs 0 immediately; the first post-reset strobe underflows.

Source files
------------

// File: rtl/tx_digital_front_end.sv
// Transmit DFE: input FIFO, linear interpolator (L = 1/2/4), gain, DC pre-compensation
// and saturation, paced by the DAC sample strobe with a two-stage output pipeline.
module tx_digital_front_end #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [1:0]  interp_sel,
  input  logic [7:0]  gain,
  input  logic [15:0] dc_offset_i,
  input  logic [15:0] dc_offset_q,
  input  logic        dac_strobe,
  output logic [15:0] dac_i,
  output logic [15:0] dac_q,
  output logic        dac_valid,
  output logic        clip,
  output logic        underflow,
  input  logic        underflow_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);

  function automatic logic [1:0] sel_to_shift(input logic [1:0] sel);
    case (sel)
      2'b01:   sel_to_shift = 2'd1;
      2'b10:   sel_to_shift = 2'd2;
      default: sel_to_shift = 2'd0;
    endcase
  endfunction

  // y = P + ((k * (C - P)) >>> log2 L); always lands between P and C, so 16 bits suffice
  function automatic logic [15:0] interp(input logic [15:0] p, input logic [15:0] c,
                                         input logic [2:0] k, input logic [1:0] sh);
    logic signed [16:0] diff;
    logic signed [19:0] prod;
    logic signed [19:0] step;
    logic signed [19:0] sum;
    diff = $signed({c[15], c}) - $signed({p[15], p});
    prod = $signed({{3{diff[16]}}, diff}) * $signed({17'd0, k});
    step = prod >>> sh;
    sum  = $signed({{4{p[15]}}, p}) + step;
    interp = sum[15:0];
  endfunction

  // Returns {saturated, value} for (y * gain) >>> 7 + offset
  function automatic logic [16:0] gain_sat(input logic [15:0] y, input logic [7:0] g,
                                           input logic [15:0] off);
    logic signed [24:0] prod;
    logic signed [24:0] scaled;
    logic signed [25:0] s;
    prod   = $signed({{9{y[15]}}, y}) * $signed({17'd0, g});
    scaled = prod >>> 7;
    s      = $signed({scaled[24], scaled}) + $signed({{10{off[15]}}, off});
    if (s > 26'sd32767) begin
      gain_sat = {1'b1, 16'h7FFF};
    end else if (s < -26'sd32768) begin
      gain_sat = {1'b1, 16'h8000};
    end else begin
      gain_sat = {1'b0, s[15:0]};
    end
  endfunction

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_r, rd_ptr_r;
  logic        full_s, empty_s, push_s, pop_s, starve_s;
  logic [31:0] head_s;

  logic [15:0] p_i_r, p_q_r, c_i_r, c_q_r;
  logic [2:0]  k_r;
  logic [1:0]  sh_r;
  logic        need_pop_r;
  logic [15:0] sel_p_i_s, sel_p_q_s, sel_c_i_s, sel_c_q_s;
  logic [2:0]  sel_k_s;
  logic [1:0]  sel_sh_s;

  logic [15:0] y_i_r, y_q_r;
  logic        s1_valid_r, s1_hold_r;
  logic [16:0] out_i_s, out_q_s;

  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign s_ready = !full_s && !rst;
  assign push_s  = s_valid && s_ready;
  assign head_s  = mem[rd_ptr_r[AW-1:0]];
  assign out_i_s = gain_sat(y_i_r, gain, dc_offset_i);
  assign out_q_s = gain_sat(y_q_r, gain, dc_offset_q);

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_r[AW-1:0]] <= s_data;
    end
  end

  // Interpolator operand selection: a pop loads P <- C, C <- head and restarts the phase
  always_comb begin
    pop_s     = 1'b0;
    starve_s  = 1'b0;
    sel_p_i_s = p_i_r;
    sel_p_q_s = p_q_r;
    sel_c_i_s = c_i_r;
    sel_c_q_s = c_q_r;
    sel_k_s   = k_r + 3'd1;
    sel_sh_s  = sh_r;
    if (dac_strobe && need_pop_r) begin
      if (!empty_s) begin
        pop_s     = 1'b1;
        sel_p_i_s = c_i_r;
        sel_p_q_s = c_q_r;
        sel_c_i_s = head_s[31:16];
        sel_c_q_s = head_s[15:0];
        sel_k_s   = 3'd1;
        sel_sh_s  = sel_to_shift(interp_sel);
      end else begin
        starve_s  = 1'b1;
      end
    end else begin
      starve_s = 1'b0;
    end
  end

  // FIFO pointers, interpolator state and both pipeline stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      p_i_r      <= 16'd0;
      p_q_r      <= 16'd0;
      c_i_r      <= 16'd0;
      c_q_r      <= 16'd0;
      k_r        <= 3'd1;
      sh_r       <= 2'd0;
      need_pop_r <= 1'b1;
      y_i_r      <= 16'd0;
      y_q_r      <= 16'd0;
      s1_valid_r <= 1'b0;
      s1_hold_r  <= 1'b0;
      dac_i      <= 16'd0;
      dac_q      <= 16'd0;
      dac_valid  <= 1'b0;
      clip       <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      if (dac_strobe && !starve_s) begin
        p_i_r      <= sel_p_i_s;
        p_q_r      <= sel_p_q_s;
        c_i_r      <= sel_c_i_s;
        c_q_r      <= sel_c_q_s;
        k_r        <= sel_k_s;
        sh_r       <= sel_sh_s;
        need_pop_r <= (sel_k_s == (3'd1 << sel_sh_s));
      end
      y_i_r      <= interp(sel_p_i_s, sel_c_i_s, sel_k_s, sel_sh_s);
      y_q_r      <= interp(sel_p_q_s, sel_c_q_s, sel_k_s, sel_sh_s);
      s1_valid_r <= dac_strobe;
      s1_hold_r  <= starve_s;
      dac_valid  <= s1_valid_r;
      // A starved strobe still pulses dac_valid but keeps the last DAC code
      if (s1_valid_r && !s1_hold_r) begin
        dac_i <= out_i_s[15:0];
        dac_q <= out_q_s[15:0];
        clip  <= out_i_s[16] | out_q_s[16];
      end else begin
        clip  <= 1'b0;
      end
      if (starve_s) begin
        underflow <= 1'b1;
      end else if (underflow_clr) begin
        underflow <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tx_digital_front_end.sv
// Directed bench for tx_digital_front_end: an L=1 vector table for the gain/offset/saturation
// path plus hand-written sequences for interpolation, underflow, backpressure and reset.
module tb_tx_digital_front_end;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [1:0]  interp_sel;
  logic [7:0]  gain;
  logic [15:0] dc_offset_i, dc_offset_q;
  logic        dac_strobe;
  logic [15:0] dac_i, dac_q;
  logic        dac_valid, clip, underflow, underflow_clr;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_i [8];
  logic [15:0] exp_q [8];
  logic        exp_c [8];

  typedef struct {
    logic [31:0] data;
    logic [7:0]  g;
    logic [15:0] oi;
    logic [15:0] oq;
    logic [15:0] ei;
    logic [15:0] eq;
    logic        ec;
  } vec_t;
  vec_t vecs [9];

  tx_digital_front_end #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .interp_sel(interp_sel), .gain(gain), .dc_offset_i(dc_offset_i), .dc_offset_q(dc_offset_q),
    .dac_strobe(dac_strobe), .dac_i(dac_i), .dac_q(dac_q), .dac_valid(dac_valid),
    .clip(clip), .underflow(underflow), .underflow_clr(underflow_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] d);
    s_data  = d;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // n back-to-back strobes; output j is checked two cycles after strobe j
  task automatic strobe_run(input int n, input string tag, input logic [1:0] sel_mid);
    for (int i = 0; i < n + 2; i++) begin
      if (i >= 2) begin
        chk($sformatf("%s_valid%0d", tag, i - 2), {31'd0, dac_valid}, 32'd1);
        chk($sformatf("%s_i%0d", tag, i - 2), {16'd0, dac_i}, {16'd0, exp_i[i-2]});
        chk($sformatf("%s_q%0d", tag, i - 2), {16'd0, dac_q}, {16'd0, exp_q[i-2]});
        chk($sformatf("%s_clip%0d", tag, i - 2), {31'd0, clip}, {31'd0, exp_c[i-2]});
      end
      if (i == 1) interp_sel = sel_mid;
      dac_strobe = (i < n);
      @(negedge clk);
    end
    dac_strobe = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h1000_F000, 8'h80, 16'h0000, 16'h0000, 16'h1000, 16'hF000, 1'b0};
    vecs[1] = '{32'h2000_E000, 8'h40, 16'h0000, 16'h0000, 16'h1000, 16'hF000, 1'b0};
    vecs[2] = '{32'h0003_FFFD, 8'h40, 16'h0000, 16'h0000, 16'h0001, 16'hFFFE, 1'b0};
    vecs[3] = '{32'h7000_0000, 8'hFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 1'b1};
    vecs[4] = '{32'h8000_0000, 8'h80, 16'hFFFF, 16'h0000, 16'h8000, 16'h0000, 1'b1};
    vecs[5] = '{32'h0100_FF00, 8'h80, 16'h0010, 16'hFFF0, 16'h0110, 16'hFEF0, 1'b0};
    vecs[6] = '{32'h0080_9000, 8'hFF, 16'h0000, 16'h0000, 16'h00FF, 16'h8000, 1'b1};
    vecs[7] = '{32'h1234_8000, 8'h00, 16'h0005, 16'hFFFB, 16'h0005, 16'hFFFB, 1'b0};
    vecs[8] = '{32'h7FF0_0000, 8'h80, 16'h0020, 16'h0000, 16'h7FFF, 16'h0000, 1'b1};

    rst = 1'b1; s_data = 32'd0; s_valid = 1'b0; interp_sel = 2'b00; gain = 8'h80;
    dc_offset_i = 16'd0; dc_offset_q = 16'd0; dac_strobe = 1'b0; underflow_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_dac_i", {16'd0, dac_i}, 32'd0);
    chk("rst_dac_q", {16'd0, dac_q}, 32'd0);
    chk("rst_flags", {29'd0, dac_valid, clip, underflow}, 32'd0);
    chk("rst_s_ready_low", {31'd0, s_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_s_ready_high", {31'd0, s_ready}, 32'd1);
    @(negedge clk);

    // L=1 table: output equals the pushed sample after gain, offset and saturation
    for (int v = 0; v < 9; v++) begin
      gain = vecs[v].g; dc_offset_i = vecs[v].oi; dc_offset_q = vecs[v].oq;
      push(vecs[v].data);
      exp_i[0] = vecs[v].ei; exp_q[0] = vecs[v].eq; exp_c[0] = vecs[v].ec;
      strobe_run(1, $sformatf("vec%0d", v), 2'b00);
    end
    // Empty FIFO: last DAC code is held, clip drops, underflow sets
    exp_i[0] = 16'h7FFF; exp_q[0] = 16'h0000; exp_c[0] = 1'b0;
    strobe_run(1, "hold", 2'b00);
    chk("hold_underflow", {31'd0, underflow}, 32'd1);

    // L=2 from reset
    gain = 8'h80; dc_offset_i = 16'd0; dc_offset_q = 16'd0;
    do_reset();
    interp_sel = 2'b01;
    push(32'h0064_0000);
    push(32'h012C_0000);
    exp_i = '{16'd50, 16'd100, 16'd200, 16'd300, 16'd0, 16'd0, 16'd0, 16'd0};
    exp_q = '{default: 16'd0};
    exp_c = '{default: 1'b0};
    strobe_run(4, "l2", 2'b01);

    // L=4 with interp_sel changed mid-segment
    do_reset();
    interp_sel = 2'b10;
    push(32'h0190_FE70);
    exp_i = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd0, 16'd0, 16'd0, 16'd0};
    exp_q = '{16'hFF9C, 16'hFF38, 16'hFED4, 16'hFE70, 16'd0, 16'd0, 16'd0, 16'd0};
    strobe_run(4, "l4", 2'b00);

    // Underflow: sticky, clearable, set wins over clear
    do_reset();
    chk("uf_initial", {31'd0, underflow}, 32'd0);
    exp_i = '{default: 16'd0};
    exp_q = '{default: 16'd0};
    strobe_run(1, "uf", 2'b00);
    chk("uf_set", {31'd0, underflow}, 32'd1);
    repeat (3) @(negedge clk);
    chk("uf_sticky", {31'd0, underflow}, 32'd1);
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
    chk("uf_cleared", {31'd0, underflow}, 32'd0);
    underflow_clr = 1'b1; dac_strobe = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0; dac_strobe = 1'b0;
    chk("uf_set_wins", {31'd0, underflow}, 32'd1);
    @(negedge clk);
    @(negedge clk);

    // Backpressure: four pushes fill the FIFO; one strobe frees a slot for the fifth
    do_reset();
    s_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      s_data = {16'(j + 1), 16'd0};
      @(negedge clk);
      if (j < 3) chk($sformatf("bp_ready%0d", j), {31'd0, s_ready}, 32'd1);
    end
    chk("bp_full", {31'd0, s_ready}, 32'd0);
    s_data = {16'd5, 16'd0};
    dac_strobe = 1'b1;
    @(negedge clk);
    dac_strobe = 1'b0;
    chk("bp_ready_after_pop", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    chk("bp_full_again", {31'd0, s_ready}, 32'd0);
    chk("bp_first_valid", {31'd0, dac_valid}, 32'd1);
    chk("bp_first_i", {16'd0, dac_i}, 32'd1);
    exp_i = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0};
    exp_q = '{default: 16'd0};
    strobe_run(4, "bp_drain", 2'b00);

    // Reset mid-stream: outputs clear at once, in-flight and queued samples are lost
    push(32'h0777_0000);
    push(32'h0888_0000);
    dac_strobe = 1'b1;
    @(negedge clk);
    dac_strobe = 1'b0;
    chk("mid_pre_i", {16'd0, dac_i}, 32'd5);
    rst = 1'b1;
    #1;
    chk("mid_rst_i", {16'd0, dac_i}, 32'd0);
    chk("mid_rst_flags", {28'd0, dac_valid, clip, underflow, s_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_no_valid", {31'd0, dac_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    exp_i = '{default: 16'd0};
    strobe_run(1, "mid_post", 2'b00);
    chk("mid_post_underflow", {31'd0, underflow}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
